spi_master_tx: RTL
==================

Name: spi_master_tx

Overview:
- Consumes the one-cycle control pulses from button_handler (next_count, start_send) and drives an SPI mode-0 (CPOL=0, CPHA=0) master transmit frame.
- Holds a DATA_W-bit value counter that next_count advances.
- start_send snapshots the counter and shifts it out MSB-first on mosi, framed by cs_n.
- Sits between button_handler and the board SPI pins.

Parameters:
- DATA_W, 8, frame and counter width in bits (legal range >= 2).
- CLK_DIV, 50, clk_100 cycles per SCLK half-period (legal range >= 1). Default gives 1 MHz SCLK.

Ports:
- clk_100  input  1  system clock, 100 MHz
- a_rst  input  1  asynchronous reset, active-high
- s_rst  input  1  synchronous reset, active-high, same effect as a_rst but applied on a clock edge
- next_count  input  1  one-cycle pulse: increment value counter
- start_send  input  1  one-cycle pulse: begin a frame
- sclk  output  1  SPI clock, idles low
- mosi  output  1  SPI data, MSB first
- cs_n  output  1  chip select, active-low
- busy  output  1  high from cycle after an accepted start_send until cs_n deasserts
- done  output  1  one-cycle pulse when a frame completes
- count_val  output  DATA_W  current value counter

Behaviour:
- All outputs are registered.
- Reset values (a_rst asynchronous, s_rst synchronous): sclk=0, mosi=0, cs_n=1, busy=0, done=0, count_val=0, state=IDLE, div_cnt=0, bit_cnt=0.
- Counter:
  - next_count high on an edge: count_val <= count_val+1, modulo 2^DATA_W (wraps from all-ones to 0).
  - Increments in every state, including during a frame.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD.
- div_cnt counts 0..CLK_DIV-1 in every non-IDLE state. A "half-tick" is div_cnt==CLK_DIV-1. It resets to 0 on every state change.
- IDLE:
  - On start_send: shreg <= count_val (the pre-increment value if next_count is simultaneous).
  - Next cycle: cs_n=0, busy=1, mosi=shreg[MSB], sclk=0, bit_cnt=0, go to SETUP.
- SETUP: sclk=0; on half-tick -> SHIFT_HI.
- SHIFT_HI:
  - sclk=1; the slave samples on this rising edge.
  - On half-tick: if bit_cnt==DATA_W-1 go to HOLD (sclk=0). Otherwise go to SHIFT_LO (sclk=0), shift shreg left, mosi = next bit, bit_cnt+1.
- SHIFT_LO: sclk=0; on half-tick -> SHIFT_HI.
- HOLD: sclk=0, mosi holds the last bit. On half-tick -> IDLE with cs_n=1, busy=0, mosi=0, done=1 for exactly one cycle.
- Frame length, cs_n low to cs_n high: CLK_DIV*(2*DATA_W+1) cycles. Defaults give 850 cycles. DATA_W=8, CLK_DIV=2 gives 34 cycles.
- Edge counts per frame: exactly DATA_W rising sclk edges; sclk never toggles while cs_n=1.
- start_send while busy is ignored: no queueing, and the frame in flight is unaffected.
- start_send in the same cycle as done=1 (state returning to IDLE) is ignored. It is accepted from the following cycle.
- Back-to-back frames: cs_n stays high for at least 1 cycle between frames.
- Reset mid-frame (either reset): the frame is aborted immediately. Outputs take reset values, with cs_n=1 and sclk=0 on the next edge (s_rst) or at once (a_rst). No done pulse is generated.
- s_rst and next_count together: s_rst wins, count_val=0.

Decomposition:
- Package spi_pkg:
  - spi_state_t enum {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD}
  - localparam SPI_CPOL=0, SPI_CPHA=0
  - DATA_W_DEF=8, CLK_DIV_DEF=50
- One sub-module, spi_tick_gen:
  - Parameter CLK_DIV; inputs clk_100, a_rst, clear, en; output half_tick.
  - Owns div_cnt.
  - The FSM asserts clear on every state change.

Test Plan (CLK_DIV=2, DATA_W=8 unless noted):
- Reset: assert a_rst mid-cycle -> outputs at reset values immediately, without waiting for a clock edge; count_val=0, cs_n=1.
- Counter: pulse next_count 3 times, then start_send -> mosi bits sampled at sclk rise = 0000_0011; 8 rising edges; cs_n low for 34 cycles; done one cycle after the last HOLD half-tick; count_val=3.
- Wrap: 256 next_count pulses -> count_val=0. With DATA_W=4, 17 pulses -> count_val=1.
- Simultaneous: count_val=0xA5, next_count and start_send in the same cycle -> frame transmits 0xA5; count_val=0xA6 afterwards.
- Ignore while busy: start_send at cycle 5 of a frame, and again in the done cycle -> only one frame and one done pulse; cs_n rises once; next start_send accepted one cycle later.
- Abort: s_rst after the 4th rising sclk edge -> next edge gives cs_n=1, sclk=0, busy=0, count_val=0, no done pulse. A following start_send sends 0x00 cleanly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 transmit master.
// Imported by the tick generator and the top level.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } spi_state_t;

    localparam int SPI_CPOL    = 0;
    localparam int SPI_CPHA    = 0;
    localparam int DATA_W_DEF  = 8;
    localparam int CLK_DIV_DEF = 50;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// SCLK half-period timer.
// Pulses half_tick on the last cycle of each half-period while enabled.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk_100,
    input  logic a_rst,
    input  logic clear,
    input  logic en,
    output logic half_tick
);

    localparam int DW = cnt_w(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;

    // Free-running divider, restarted whenever the FSM changes state.
    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            r_div_cnt <= '0;
        end else if (clear || !en || (r_div_cnt == LAST)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign half_tick = en && (r_div_cnt == LAST);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit master with a button-driven value counter.
// start_send snapshots the counter and shifts it out MSB first.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic              clk_100,
    input  logic              a_rst,
    input  logic              s_rst,
    input  logic              next_count,
    input  logic              start_send,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] count_val
);

    localparam int BW = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic SCLK_IDLE = 1'(SPI_CPOL);

    spi_state_t        r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs_n;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_count;

    spi_state_t        w_state_nxt;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic [BW-1:0]     w_bit_nxt;
    logic              w_sclk_nxt;
    logic              w_mosi_nxt;
    logic              w_cs_n_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_half_tick;
    logic              w_clear;
    logic              w_en;

    assign w_en    = (r_state != IDLE);
    assign w_clear = (w_state_nxt != r_state) || s_rst;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_100   (clk_100),
        .a_rst     (a_rst),
        .clear     (w_clear),
        .en        (w_en),
        .half_tick (w_half_tick)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_bit_nxt   = r_bit_cnt;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_cs_n_nxt  = r_cs_n;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // The done cycle itself never accepts a new frame.
                if (start_send && !r_done) begin
                    w_state_nxt = SETUP;
                    w_shreg_nxt = r_count;
                    w_mosi_nxt  = r_count[DATA_W-1];
                    w_cs_n_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_sclk_nxt  = SCLK_IDLE;
                    w_bit_nxt   = '0;
                end
            end
            SETUP: begin
                if (w_half_tick) begin
                    w_state_nxt = SHIFT_HI;
                    w_sclk_nxt  = ~SCLK_IDLE;
                end
            end
            SHIFT_HI: begin
                if (w_half_tick) begin
                    w_sclk_nxt = SCLK_IDLE;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = SHIFT_LO;
                        w_shreg_nxt = {r_shreg[DATA_W-2:0], 1'b0};
                        w_mosi_nxt  = r_shreg[DATA_W-2];
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                    end
                end
            end
            SHIFT_LO: begin
                if (w_half_tick) begin
                    w_state_nxt = SHIFT_HI;
                    w_sclk_nxt  = ~SCLK_IDLE;
                end
            end
            HOLD: begin
                if (w_half_tick) begin
                    w_state_nxt = IDLE;
                    w_cs_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_mosi_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM and output registers; either reset aborts a frame silently.
    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= SCLK_IDLE;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (s_rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= SCLK_IDLE;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Value counter, advancing in every state; s_rst beats next_count.
    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            r_count <= '0;
        end else if (s_rst) begin
            r_count <= '0;
        end else if (next_count) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign sclk      = r_sclk;
    assign mosi      = r_mosi;
    assign cs_n      = r_cs_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign count_val = r_count;

endmodule
